// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port memory between the CPU datapath and the debug/loader port.
// Latency: ack pulses LAT+1 cycles after the grant edge; back in IDLE LAT+2 cycles after the sampled req.
// Backpressure: req/ack handshake; the loser keeps req high and waits, the CPU sees cpu_stall until cpu_ack.
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LAT      = 2,
  parameter int HOLD_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  localparam int SW = $clog2(HOLD_MAX + 1);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak;
  logic          we_q;
  logic          owner_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          grant;
  logic          grant_dbg;
  logic          streak_full;
  logic          last_cycle;

  assign streak_full = (streak == SW'(HOLD_MAX));
  assign last_cycle  = (cnt == '0);

  // Memory sees only latched values, never the requester inputs directly.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = owner_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

  // State register; reset drops straight to IDLE so strobes and busy fall asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, arbitration and decoded outputs.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_dbg = 1'b0;
    busy      = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    cpu_ack   = 1'b0;
    dbg_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req | dbg_req) begin
          grant = 1'b1;
          // Debug normally wins a tie; a full streak hands the slot to the CPU.
          grant_dbg = dbg_req & (~cpu_req | ~streak_full);
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        busy   = 1'b1;
        mem_re = ~we_q;
        mem_we = we_q;
        if (last_cycle) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        busy      = 1'b1;
        cpu_ack   = ~owner_q;
        dbg_ack   = owner_q;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Transaction latch, wait counter, fairness streak and per-owner read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      streak    <= '0;
      we_q      <= 1'b0;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      if (grant) begin
        owner_q <= grant_dbg;
        we_q    <= grant_dbg ? dbg_we    : cpu_we;
        addr_q  <= grant_dbg ? dbg_addr  : cpu_addr;
        wdata_q <= grant_dbg ? dbg_wdata : cpu_wdata;
        cnt     <= CW'(LAT - 1);
        // Only debug grants taken while the CPU is waiting count toward the streak.
        if (grant_dbg && cpu_req) begin
          if (!streak_full) begin
            streak <= streak + SW'(1);
          end
        end else begin
          streak <= '0;
        end
      end
      if (state == ACCESS) begin
        if (!last_cycle) begin
          cnt <= cnt - CW'(1);
        end else if (!we_q) begin
          if (owner_q) begin
            dbg_rdata <= mem_rdata;
          end else begin
            cpu_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter: vector table, corner-case sequences, random vs. model.
// Latency: expects ack LAT+1 edges after the request is sampled, one idle cycle between transactions.
// Backpressure: requesters hold req/addr/we/wdata until their ack, then may re-request at once.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int LAT      = 2;
  localparam int HOLD_MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_ack;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_re, mem_we, owner, busy;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory device: combinational read, write on the clock edge while mem_we is high.
  logic [DW-1:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] = mem_wdata;

  typedef struct {
    bit            dbg;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;     // requester's own rdata at its ack
    logic [DW-1:0] exp_other;  // the other port's rdata at that ack
  } vec_t;

  typedef struct {
    bit            v;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } tx_t;

  vec_t          vecs [7];
  tx_t           cpu_tx, dbg_tx, cur;
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] exp_cpu_rd, exp_dbg_rd;
  int            phase, streak_m;
  bit            cur_dbg, creq, dreq, in_access, resp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_ack(input bit dbg, input string name);
    int n = 0;
    while (!(dbg ? dbg_ack : cpu_ack) && n < 20) begin
      step();
      n++;
    end
    chk({name, " ack seen"}, dbg ? dbg_ack : cpu_ack, 1);
  endtask

  // One isolated transaction from a vector: timing, strobes, address/data, rdata of both ports.
  task automatic run_vec(input vec_t v, input int idx);
    int n = 0;
    int strobes = 0;
    bit acked = 0;
    if (v.dbg) begin
      dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    while (!acked && n < 20) begin
      step();
      n++;
      if (v.dbg ? dbg_ack : cpu_ack) begin
        acked = 1;
      end else if (mem_re || mem_we) begin
        strobes++;
        chk($sformatf("v%0d mem_addr", idx), mem_addr, v.addr);
        chk($sformatf("v%0d strobe kind", idx), {mem_we, mem_re}, v.we ? 2'b10 : 2'b01);
        if (v.we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
        if (!v.dbg) chk($sformatf("v%0d cpu_stall in access", idx), cpu_stall, 1);
      end
    end
    chk($sformatf("v%0d ack latency", idx), n, LAT + 1);
    chk($sformatf("v%0d strobe cycles", idx), strobes, LAT);
    chk($sformatf("v%0d owner", idx), owner, v.dbg);
    chk($sformatf("v%0d own rdata", idx), v.dbg ? dbg_rdata : cpu_rdata, v.exp_rd);
    chk($sformatf("v%0d other rdata", idx), v.dbg ? cpu_rdata : dbg_rdata, v.exp_other);
    chk($sformatf("v%0d other ack", idx), v.dbg ? cpu_ack : dbg_ack, 0);
    if (!v.dbg) chk($sformatf("v%0d cpu_stall at ack", idx), cpu_stall, 0);
    idle_inputs();
    step();
    chk($sformatf("v%0d ack one cycle", idx), {cpu_ack, dbg_ack}, 2'b00);
    chk($sformatf("v%0d busy after", idx), busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, nack, ngr, n;
    bit prev_busy, seen;
    logic [DW-1:0] rd1;
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b0, 32'h20, 32'h0,         32'h12345678, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'hDEADBEEF, 32'h12345678};
    vecs[4] = '{1'b0, 1'b1, 32'h30, 32'hA5A50F0F,  32'h12345678, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 32'h30, 32'h0,         32'hA5A50F0F, 32'h12345678};
    vecs[6] = '{1'b0, 1'b0, 32'h30, 32'h0,         32'hA5A50F0F, 32'hA5A50F0F};

    for (int i = 0; i < 256; i++) mem[i] = 32'h5A000000 | 32'(i * 7);
    mem[8'h10] = 32'hDEADBEEF;

    // Reset values.
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    chk("reset cpu_rdata", cpu_rdata, 0);
    chk("reset dbg_rdata", dbg_rdata, 0);
    chk("reset acks", {cpu_ack, dbg_ack}, 2'b00);
    chk("reset strobes", {mem_re, mem_we}, 2'b00);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset owner/busy", {owner, busy}, 2'b00);
    chk("reset cpu_stall", cpu_stall, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Simultaneous requests: debug first, CPU in the next IDLE.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
    step();
    chk("simul first owner", owner, 1);
    chk("simul first busy", busy, 1);
    wait_ack(1'b1, "simul dbg");
    chk("simul dbg_rdata", dbg_rdata, 32'h12345678);
    dbg_req = 1'b0;
    step();
    chk("simul gap idle", busy, 0);
    step();
    chk("simul second owner", owner, 0);
    chk("simul second busy", busy, 1);
    wait_ack(1'b0, "simul cpu");
    chk("simul cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    idle_inputs();
    step();

    // Back-to-back CPU reads with a new address presented at the first ack.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    t1 = 0; t2 = 0; nack = 0; rd1 = '0;
    for (int c = 1; c <= 30 && nack < 2; c++) begin
      step();
      if (cpu_ack) begin
        nack++;
        if (nack == 1) begin t1 = c; rd1 = cpu_rdata; cpu_addr = 32'h20; end
        else t2 = c;
      end
    end
    chk("b2b ack count", nack, 2);
    chk("b2b ack spacing", t2 - t1, LAT + 2);
    chk("b2b first rdata", rd1, 32'hDEADBEEF);
    chk("b2b second rdata", cpu_rdata, 32'h12345678);
    idle_inputs();
    step();

    // Reset in the second ACCESS cycle of a CPU write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hCAFE0001;
    step();
    chk("rstmid access1 mem_we", mem_we, 1);
    step();
    chk("rstmid access2 mem_we", mem_we, 1);
    rst = 1'b1;
    #1;
    chk("rstmid mem_we", mem_we, 0);
    chk("rstmid busy", busy, 0);
    chk("rstmid owner", owner, 0);
    chk("rstmid acks", {cpu_ack, dbg_ack}, 2'b00);
    idle_inputs();
    step();
    chk("rstmid held busy", busy, 0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (cpu_ack || busy) seen = 1;
    end
    chk("rstmid no ack after reset", seen, 0);
    v = '{1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0};
    run_vec(v, 100);

    // Starvation guard: both requesters held high, grant order 1111 0 1111 0.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
    ngr = 0; n = 0;
    prev_busy = busy;
    while (ngr < 10 && n < 200) begin
      step();
      n++;
      if (busy && !prev_busy) begin
        chk($sformatf("starve grant %0d owner", ngr), owner, (ngr % 5 == 4) ? 1'b0 : 1'b1);
        ngr++;
      end
      prev_busy = busy;
    end
    chk("starve grant count", ngr, 10);
    idle_inputs();

    // Random traffic against a transaction-level model.
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    cpu_tx = '{0, 0, '0, '0};
    dbg_tx = '{0, 0, '0, '0};
    cur = '{0, 0, '0, '0};
    phase = 0; streak_m = 0; cur_dbg = 0;
    exp_cpu_rd = '0; exp_dbg_rd = '0;
    for (int c = 0; c < 3000; c++) begin
      cpu_req = cpu_tx.v; cpu_we = cpu_tx.we; cpu_addr = cpu_tx.addr; cpu_wdata = cpu_tx.wdata;
      dbg_req = dbg_tx.v; dbg_we = dbg_tx.we; dbg_addr = dbg_tx.addr; dbg_wdata = dbg_tx.wdata;
      creq = cpu_tx.v;
      dreq = dbg_tx.v;
      // Model the coming edge: phase 0 idle, 1..LAT memory access, LAT+1 response.
      if (phase == 0) begin
        if (creq || dreq) begin
          cur_dbg = dreq && (!creq || streak_m < HOLD_MAX);
          cur = cur_dbg ? dbg_tx : cpu_tx;
          if (cur_dbg && creq) streak_m = (streak_m < HOLD_MAX) ? streak_m + 1 : HOLD_MAX;
          else streak_m = 0;
          phase = 1;
        end
      end else if (phase <= LAT) begin
        phase = phase + 1;
      end else begin
        phase = 0;
      end
      resp = (phase == LAT + 1);
      in_access = (phase >= 1 && phase <= LAT);
      if (resp) begin
        if (cur.we) ref_mem[cur.addr[7:0]] = cur.wdata;
        else if (cur_dbg) exp_dbg_rd = ref_mem[cur.addr[7:0]];
        else exp_cpu_rd = ref_mem[cur.addr[7:0]];
      end
      step();
      chk("rnd busy", busy, phase != 0);
      chk("rnd mem_re", mem_re, in_access && !cur.we);
      chk("rnd mem_we", mem_we, in_access && cur.we);
      chk("rnd cpu_ack", cpu_ack, resp && !cur_dbg);
      chk("rnd dbg_ack", dbg_ack, resp && cur_dbg);
      chk("rnd cpu_rdata", cpu_rdata, exp_cpu_rd);
      chk("rnd dbg_rdata", dbg_rdata, exp_dbg_rd);
      chk("rnd cpu_stall", cpu_stall, creq && !(resp && !cur_dbg));
      if (phase != 0) chk("rnd owner", owner, cur_dbg);
      if (in_access) begin
        chk("rnd mem_addr", mem_addr, cur.addr);
        if (cur.we) chk("rnd mem_wdata", mem_wdata, cur.wdata);
      end
      if (resp) begin
        if (cur_dbg) dbg_tx.v = 0;
        else cpu_tx.v = 0;
      end
      if (!cpu_tx.v && $urandom_range(0, 3) != 0) begin
        cpu_tx.v = 1;
        cpu_tx.we = $urandom_range(0, 1) == 1;
        cpu_tx.addr = AW'($urandom_range(0, 15) * 4);
        cpu_tx.wdata = $urandom;
      end
      if (!dbg_tx.v && $urandom_range(0, 7) != 0) begin
        dbg_tx.v = 1;
        dbg_tx.we = $urandom_range(0, 1) == 1;
        dbg_tx.addr = AW'($urandom_range(0, 15) * 4);
        dbg_tx.wdata = $urandom;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
